// File: rtl/shift_pkg.sv
// shift_pkg: shift opcodes, Shift unit control codes, sequencer states and decode record.
package shift_pkg;
  localparam logic [1:0] SHIFT_SLL = 2'b00;
  localparam logic [1:0] SHIFT_SRL = 2'b01;
  localparam logic [1:0] SHIFT_SRA = 2'b10;
  localparam logic [5:0] F_SLL  = 6'b000000;
  localparam logic [5:0] F_SRL  = 6'b000010;
  localparam logic [5:0] F_SRA  = 6'b000011;
  localparam logic [5:0] F_SLLV = 6'b000100;
  localparam logic [5:0] F_SRLV = 6'b000110;
  localparam logic [5:0] F_SRAV = 6'b000111;
  typedef enum logic [1:0] {S_IDLE, S_EXEC, S_DONE} state_t;
  typedef struct packed {
    logic       legal;
    logic [1:0] ctrl;
    logic       use_rs;
  } decode_t;
endpackage

// File: rtl/shift_funct_decode.sv
// shift_funct_decode: maps an R-type funct field to legality, Shift unit control and amount source.
module shift_funct_decode
  import shift_pkg::*;
(
  input  logic [5:0] funct_i,
  output decode_t    dec_o
);
  // The six shifts are exactly 000xyz with yz != 01; bit 2 selects the variable form.
  always_comb begin
    dec_o.legal  = (funct_i[5:3] == 3'b000) && (funct_i[1:0] != 2'b01);
    dec_o.use_rs = funct_i[2];
    dec_o.ctrl   = funct_i[1] ? (funct_i[0] ? SHIFT_SRA : SHIFT_SRL) : SHIFT_SLL;
  end
endmodule

// File: rtl/shift_sequencer.sv
// shift_sequencer: multicycle controller that feeds the external Shift unit and hands
// the captured result back to the main control unit with a start/done handshake.
module shift_sequencer
  import shift_pkg::*;
#(
  parameter int DATA_W      = 32,
  parameter int SHAMT_W     = 5,
  parameter int EXEC_CYCLES = 1
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               start,
  input  logic [5:0]         funct,
  input  logic [SHAMT_W-1:0] shamt_field,
  input  logic [DATA_W-1:0]  rs_val,
  input  logic [DATA_W-1:0]  rt_val,
  output logic               busy,
  output logic               done,
  output logic               wr_en,
  output logic               err,
  output logic [DATA_W-1:0]  result,
  output logic [1:0]         shift_ctrl,
  output logic [SHAMT_W-1:0] shamt,
  output logic [DATA_W-1:0]  shift_src,
  input  logic [DATA_W-1:0]  shift_out
);
  localparam logic [3:0] LAST = 4'(EXEC_CYCLES - 1);
  decode_t dec;
  state_t state_q, state_d;
  logic [3:0] cnt_q, cnt_d;
  logic [1:0] ctrl_q, ctrl_d;
  logic [SHAMT_W-1:0] amt_q, amt_d;
  logic [DATA_W-1:0] src_q, src_d, result_q, result_d;
  logic err_q, err_d;
  logic exec;
  logic unused_rs;
  assign unused_rs = ^rs_val[DATA_W-1:SHAMT_W];
  shift_funct_decode u_dec (
    .funct_i(funct),
    .dec_o  (dec)
  );
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    ctrl_d   = ctrl_q;
    amt_d    = amt_q;
    src_d    = src_q;
    result_d = result_q;
    err_d    = err_q;
    case (state_q)
      S_IDLE: if (start) begin
        err_d   = !dec.legal;
        state_d = dec.legal ? S_EXEC : S_DONE;
        if (dec.legal) begin
          ctrl_d = dec.ctrl;
          amt_d  = dec.use_rs ? rs_val[SHAMT_W-1:0] : shamt_field;
          src_d  = rt_val;
          cnt_d  = '0;
        end
      end
      S_EXEC: begin
        cnt_d = cnt_q + 4'd1;
        if (cnt_q == LAST) begin
          result_d = shift_out;
          state_d  = S_DONE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      ctrl_q   <= SHIFT_SLL;
      amt_q    <= '0;
      src_q    <= '0;
      result_q <= '0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      ctrl_q   <= ctrl_d;
      amt_q    <= amt_d;
      src_q    <= src_d;
      result_q <= result_d;
      err_q    <= err_d;
    end
  end
  assign exec       = state_q == S_EXEC;
  assign busy       = state_q != S_IDLE;
  assign done       = state_q == S_DONE;
  assign wr_en      = done && !err_q;
  assign err        = done && err_q;
  assign result     = result_q;
  assign shift_ctrl = exec ? ctrl_q : SHIFT_SLL;
  assign shamt      = exec ? amt_q : '0;
  assign shift_src  = exec ? src_q : '0;
endmodule

// File: tb/tb_shift_sequencer.sv
// tb_shift_sequencer: directed checks of two sequencers (EXEC_CYCLES 1 and 3) driving a behavioural Shift unit.
module tb_shift_sequencer;
  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        start = 1'b0;
  logic [5:0]  funct = '0;
  logic [4:0]  shamt_field = '0;
  logic [31:0] rs_val = '0;
  logic [31:0] rt_val = '0;
  logic        busy, done, wr_en, err, busy3, done3, wr_en3, err3;
  logic [31:0] result, shift_src, shift_out, result3, shift_src3, shift_out3;
  logic [1:0]  shift_ctrl, shift_ctrl3;
  logic [4:0]  shamt, shamt3;
  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  function automatic logic [31:0] shifter(input logic [1:0] c, input logic [4:0] a, input logic [31:0] s);
    return c == 2'b00 ? s << a : c == 2'b01 ? s >> a : c == 2'b10 ? 32'($signed(s) >>> a) : 32'h0;
  endfunction

  assign shift_out  = shifter(shift_ctrl, shamt, shift_src);
  assign shift_out3 = shifter(shift_ctrl3, shamt3, shift_src3);

  shift_sequencer u_dut (
    .clk(clk), .reset_n(reset_n), .start(start), .funct(funct), .shamt_field(shamt_field),
    .rs_val(rs_val), .rt_val(rt_val), .busy(busy), .done(done), .wr_en(wr_en), .err(err),
    .result(result), .shift_ctrl(shift_ctrl), .shamt(shamt), .shift_src(shift_src),
    .shift_out(shift_out)
  );

  shift_sequencer #(.EXEC_CYCLES(3)) u_dut3 (
    .clk(clk), .reset_n(reset_n), .start(start), .funct(funct), .shamt_field(shamt_field),
    .rs_val(rs_val), .rt_val(rt_val), .busy(busy3), .done(done3), .wr_en(wr_en3), .err(err3),
    .result(result3), .shift_ctrl(shift_ctrl3), .shamt(shamt3), .shift_src(shift_src3),
    .shift_out(shift_out3)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic [5:0] f, input logic [4:0] sf, input logic [31:0] rs, input logic [31:0] rt);
    funct = f; shamt_field = sf; rs_val = rs; rt_val = rt; start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic legal_op(input string tag, input logic [5:0] f, input logic [4:0] sf,
                          input logic [31:0] rs, input logic [31:0] rt,
                          input logic [1:0] ec, input logic [4:0] ea, input logic [31:0] er);
    issue(f, sf, rs, rt);
    check({tag, " exec busy"}, 32'(busy), 1);
    check({tag, " exec done"}, 32'(done), 0);
    check({tag, " ctrl"}, 32'(shift_ctrl), 32'(ec));
    check({tag, " shamt"}, 32'(shamt), 32'(ea));
    check({tag, " src"}, shift_src, rt);
    tick();
    check({tag, " done"}, 32'(done), 1);
    check({tag, " wr_en"}, 32'(wr_en), 1);
    check({tag, " err"}, 32'(err), 0);
    check({tag, " result"}, result, er);
    check({tag, " done shamt idle"}, 32'(shamt), 0);
    tick();
    check({tag, " idle done"}, 32'(done), 0);
    check({tag, " idle busy"}, 32'(busy), 0);
    check({tag, " idle wr_en"}, 32'(wr_en), 0);
  endtask

  initial begin
    #12;
    check("rst busy", 32'(busy), 0);
    check("rst done", 32'(done), 0);
    check("rst result", result, 0);
    check("rst ctrl", 32'(shift_ctrl), 0);
    check("rst src", shift_src, 0);
    reset_n = 1'b1;
    tick();
    legal_op("sll",  6'b000000, 5'd3, 32'h0,        32'd10,       2'b00, 5'd3,  32'd80);
    legal_op("srlv", 6'b000110, 5'd0, 32'd10,       32'hFFFFFFEF, 2'b01, 5'd10, 32'h003FFFFF);
    legal_op("srav", 6'b000111, 5'd0, 32'h3F,       32'hFFFFFFEF, 2'b10, 5'd31, 32'hFFFFFFFF);
    legal_op("sra",  6'b000011, 5'd1, 32'h0,        32'hFFFFFFEF, 2'b10, 5'd1,  32'hFFFFFFF7);
    legal_op("srl",  6'b000010, 5'd31, 32'h0,       32'h80000000, 2'b01, 5'd31, 32'h1);
    legal_op("sllv0", 6'b000100, 5'd7, 32'hFFFFFFE0, 32'h12345678, 2'b00, 5'd0, 32'h12345678);
    issue(6'b100000, 5'd2, 32'h0, 32'h5);
    check("ill done", 32'(done), 1);
    check("ill err", 32'(err), 1);
    check("ill wr_en", 32'(wr_en), 0);
    check("ill result", result, 32'h12345678);
    tick();
    check("ill idle err", 32'(err), 0);
    check("ill idle busy", 32'(busy), 0);
    repeat (4) tick();
    funct = 6'b000010; shamt_field = 5'd4; rt_val = 32'h100; start = 1'b1;
    tick();
    rt_val = 32'hFFFF0000;
    check("hold e1 busy", 32'(busy3), 1);
    check("hold e1 src", shift_src3, 32'h100);
    tick();
    check("hold e2 done", 32'(done3), 0);
    tick();
    check("hold e3 done", 32'(done3), 0);
    tick();
    check("hold op1 done", 32'(done3), 1);
    check("hold op1 wr_en", 32'(wr_en3), 1);
    check("hold op1 result", result3, 32'h10);
    tick();
    check("hold idle busy", 32'(busy3), 0);
    check("hold idle done", 32'(done3), 0);
    tick();
    check("hold op2 busy", 32'(busy3), 1);
    check("hold op2 src", shift_src3, 32'hFFFF0000);
    start = 1'b0;
    repeat (2) tick();
    check("hold op2 early", 32'(done3), 0);
    tick();
    check("hold op2 done", 32'(done3), 1);
    check("hold op2 result", result3, 32'h0FFFF000);
    tick();
    issue(6'b000000, 5'd2, 32'h0, 32'h3);
    check("abort pre busy", 32'(busy), 1);
    #2 reset_n = 1'b0;
    #1;
    check("abort busy", 32'(busy), 0);
    check("abort shamt", 32'(shamt), 0);
    check("abort src", shift_src, 0);
    check("abort result", result, 0);
    tick();
    check("abort done", 32'(done), 0);
    check("abort wr_en", 32'(wr_en), 0);
    reset_n = 1'b1;
    tick();
    check("abort post done", 32'(done), 0);
    legal_op("after", 6'b000100, 5'd0, 32'h4, 32'h3, 2'b00, 5'd4, 32'h30);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/shift_sequencer.md
Name: shift_sequencer

Overview:
- Multicycle control block that sequences the shared combinational Shift unit for MIPS R-type shifts: SLL, SRL, SRA, SLLV, SRLV and SRAV.
- Decodes funct, selects the shift amount (shamt field or rs[4:0]) and latches operands.
- Drives the Shift unit's shift_ctrl/shamt/shift_src for a programmable number of cycles, captures shift_out, then signals writeback to the main control unit with a start/done handshake.

Parameters:
- DATA_W, 32, operand and result width.
- SHAMT_W, 5, shift-amount width.
- EXEC_CYCLES, 1, cycles the Shift unit is held stable before shift_out is captured (1..15).

Ports:
- clk  in  1  system clock, rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- start  in  1  request pulse; sampled only in IDLE.
- funct  in  6  R-type funct field.
- shamt_field  in  SHAMT_W  instruction shamt field.
- rs_val  in  DATA_W  rs register value (variable shift amount source).
- rt_val  in  DATA_W  rt register value (shift source).
- busy  out  1  high in every state except IDLE.
- done  out  1  one-cycle completion pulse.
- wr_en  out  1  one-cycle rd write enable; coincident with done on legal ops.
- err  out  1  one-cycle illegal-funct flag; coincident with done.
- result  out  DATA_W  registered shift result.
- shift_ctrl  out  2  to Shift unit: 00 SLL, 01 SRL, 10 SRA.
- shamt  out  SHAMT_W  to Shift unit.
- shift_src  out  DATA_W  to Shift unit.
- shift_out  in  DATA_W  from Shift unit.

Behaviour:
- Reset (async, reset_n low): state IDLE; busy, done, wr_en and err are 0; result 0; shift_ctrl 00, shamt 0, shift_src 0; cycle counter 0.
- Funct decode:
  - 000000 SLL: shamt_field, ctrl 00.
  - 000010 SRL: shamt_field, ctrl 01.
  - 000011 SRA: shamt_field, ctrl 10.
  - 000100 SLLV: rs_val[4:0], ctrl 00.
  - 000110 SRLV: rs_val[4:0], ctrl 01.
  - 000111 SRAV: rs_val[4:0], ctrl 10.
  - Any other funct is illegal.
- ctrl 11 is never driven.
- States: IDLE, EXEC, DONE.
- IDLE:
  - Shifter outputs are driven to 0.
  - start=1 with legal funct: latch ctrl/amount/rt_val into operand registers, clear counter, go to EXEC.
  - start=1 with illegal funct: set err_pending, go directly to DONE.
- EXEC:
  - shift_ctrl/shamt/shift_src come from the operand registers and are held stable.
  - Counter increments every cycle.
  - On the edge where counter == EXEC_CYCLES-1: result <= shift_out, go to DONE.
- DONE:
  - done=1 for exactly one cycle.
  - Legal op: wr_en=1, err=0. Illegal op: wr_en=0, err=1, result unchanged.
  - Unconditionally return to IDLE.
  - Shifter outputs return to 0.
- Latency: start sampled at edge k -> done high during the cycle after edge k+EXEC_CYCLES (2 cycles with default). Illegal op: done in the cycle after edge k.
- Throughput: start is ignored while busy, including start asserted during DONE. A new request is accepted at the earliest on the first IDLE cycle after DONE.
- Operands are latched at acceptance; changes on funct/rs_val/rt_val/shamt_field during EXEC do not affect result.
- Only rs_val[4:0] is used for variable shifts; upper bits are ignored (rs=0x3F -> shift 31).
- Shift by 0 is legal: result = rt_val.
- result holds its value until the next legal completion or reset.
- Reset mid-operation: immediate return to reset values. No done or wr_en is produced for the aborted op.

Decomposition:
- Shared package (shift_pkg): SHIFT_SLL=2'b00, SHIFT_SRL=2'b01, SHIFT_SRA=2'b10; funct constants for the six shift opcodes; state encoding IDLE/EXEC/DONE. The Shift unit and the main control unit import the same package.
- One natural sub-module: shift_funct_decode (combinational funct -> {legal, ctrl, use_rs_amount}).
- The Shift unit stays external, connected at the datapath level; this block does not instantiate it.

Test Plan:
- SLL, rt=10, shamt_field=3, EXEC_CYCLES=1 -> shift_ctrl 00/shamt 3 during EXEC; result 80; done and wr_en high 2 cycles after start edge, one cycle wide.
- SRLV, rs=10, rt=-17 (0xFFFFFFEF) -> shift_ctrl 01, shamt 10; result 0x003FFFFF.
- SRAV, rs=0x0000003F, rt=-17 -> shamt 31, shift_ctrl 10, result 0xFFFFFFFF. SRA shamt_field=1, rt=-17 -> result 0xFFFFFFF7 (-9).
- funct=100000 with start -> done+err one cycle after start edge; wr_en 0; result unchanged from previous op.
- start held high continuously, plus rt_val changed during EXEC (EXEC_CYCLES=3) -> exactly one op per IDLE visit; result uses latched rt; done at 4 cycles after accept edge.
- reset_n pulsed low during EXEC -> all outputs 0 immediately; no done/wr_en; next start after release completes normally.
